// File: rtl/udt_axis_gate.sv
// udt_axis_gate: AXI-Stream pass gate controlled by UDT socket state codes.
// The gate opens on a CONNECT code and closes on a CLOSE code, but only on
// packet boundaries, so downstream never sees a partial packet.
//
// Handshake: a beat transfers on any cycle where tvalid and tready are both
// high. Data, keep and last pass through combinationally. m_axis_tvalid is
// s_axis_tvalid qualified by the gate, and s_axis_tready is m_axis_tready
// while passing. While closed, s_axis_tready is low (backpressure), or high
// when DROP_WHEN_CLOSED=1, in which case beats are accepted and thrown away.
module udt_axis_gate #(
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned COUNT_WIDTH      = 32,
    parameter logic [31:0] CONNECT          = 32'h0000_0001,
    parameter logic [31:0] CLOSE            = 32'h0000_0002,
    parameter int unsigned DROP_WHEN_CLOSED = 0
) (
    input  logic                      tx_axis_aclk,
    input  logic                      tx_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    input  logic [31:0]               udt_state_i,
    input  logic                      state_valid_i,
    output logic                      gate_open_o,
    output logic                      in_packet_o,
    output logic [COUNT_WIDTH-1:0]    pkt_count_o,
    output logic [COUNT_WIDTH-1:0]    drop_count_o
);

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_SYNC   = 2'd3
    } state_t;

    localparam logic DROP = (DROP_WHEN_CLOSED != 0);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_next;
    logic   in_packet;
    logic   in_next;
    logic   pass;
    logic   beat;
    logic   last_beat;
    logic   cmd_connect;
    logic   cmd_close;

    assign pass        = (state == ST_OPEN) || (state == ST_DRAIN);
    assign cmd_connect = state_valid_i && (udt_state_i == CONNECT);
    assign cmd_close   = state_valid_i && (udt_state_i == CLOSE);

    // Ready is held low during reset so nothing is accepted while the gate is unknown.
    assign s_axis_tready = tx_axis_aresetn & (pass ? m_axis_tready : DROP);
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = s_axis_tvalid & pass;

    assign beat      = s_axis_tvalid & s_axis_tready;
    assign last_beat = beat & s_axis_tlast;
    // Packet position as it will be after this cycle's beat (if any).
    assign in_next   = beat ? ~s_axis_tlast : in_packet;

    assign gate_open_o = pass;
    assign in_packet_o = in_packet;

    // State and packet-position registers.
    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            state     <= ST_CLOSED;
            in_packet <= 1'b0;
        end else begin
            state     <= state_next;
            in_packet <= in_next;
        end
    end

    // Next-state decode; transitions only move the gate on packet boundaries.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLOSED: begin
                // A dropped packet still in flight must finish before opening.
                if (cmd_connect) state_next = (in_next && DROP) ? ST_SYNC : ST_OPEN;
            end
            ST_OPEN: begin
                if (cmd_close) state_next = in_next ? ST_DRAIN : ST_CLOSED;
            end
            ST_DRAIN: begin
                if (cmd_connect)    state_next = ST_OPEN;
                else if (last_beat) state_next = ST_CLOSED;
            end
            ST_SYNC: begin
                if (cmd_close)      state_next = ST_CLOSED;
                else if (last_beat) state_next = ST_OPEN;
            end
            default: state_next = ST_CLOSED;
        endcase
    end

    // Saturating counters of forwarded and discarded packets.
    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            pkt_count_o  <= '0;
            drop_count_o <= '0;
        end else begin
            if (last_beat && pass && (pkt_count_o != '1))
                pkt_count_o <= pkt_count_o + CNT_ONE;
            if (last_beat && !pass && DROP && (drop_count_o != '1))
                drop_count_o <= drop_count_o + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_udt_axis_gate.sv
// Directed testbench for udt_axis_gate. Instance a: backpressure mode with
// 4-bit counters; instance b: drop mode with 8-bit counters.
module tb_udt_axis_gate;
  localparam logic [31:0] CON = 32'h0000_0001;
  localparam logic [31:0] CLS = 32'h0000_0002;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // instance a signals
  logic        a_rst_n;
  logic [31:0] a_s_tdata;
  logic [3:0]  a_s_tkeep;
  logic        a_s_tvalid, a_s_tlast, a_s_tready;
  logic [31:0] a_m_tdata;
  logic [3:0]  a_m_tkeep;
  logic        a_m_tvalid, a_m_tlast, a_m_tready;
  logic [31:0] a_udt;
  logic        a_sv, a_gate, a_inpkt;
  logic [3:0]  a_pkt, a_drop;

  // instance b signals
  logic        b_rst_n;
  logic [31:0] b_s_tdata;
  logic [3:0]  b_s_tkeep;
  logic        b_s_tvalid, b_s_tlast, b_s_tready;
  logic [31:0] b_m_tdata;
  logic [3:0]  b_m_tkeep;
  logic        b_m_tvalid, b_m_tlast, b_m_tready;
  logic [31:0] b_udt;
  logic        b_sv, b_gate, b_inpkt;
  logic [7:0]  b_pkt, b_drop;

  udt_axis_gate #(.DATA_WIDTH(32), .COUNT_WIDTH(4), .CONNECT(CON), .CLOSE(CLS), .DROP_WHEN_CLOSED(0)) dut_a (
    .tx_axis_aclk(clk), .tx_axis_aresetn(a_rst_n),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_s_tkeep), .s_axis_tvalid(a_s_tvalid),
    .s_axis_tlast(a_s_tlast), .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
    .m_axis_tlast(a_m_tlast), .m_axis_tready(a_m_tready),
    .udt_state_i(a_udt), .state_valid_i(a_sv), .gate_open_o(a_gate), .in_packet_o(a_inpkt),
    .pkt_count_o(a_pkt), .drop_count_o(a_drop));

  udt_axis_gate #(.DATA_WIDTH(32), .COUNT_WIDTH(8), .CONNECT(CON), .CLOSE(CLS), .DROP_WHEN_CLOSED(1)) dut_b (
    .tx_axis_aclk(clk), .tx_axis_aresetn(b_rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tlast(b_s_tlast), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tlast(b_m_tlast), .m_axis_tready(b_m_tready),
    .udt_state_i(b_udt), .state_valid_i(b_sv), .gate_open_o(b_gate), .in_packet_o(b_inpkt),
    .pkt_count_o(b_pkt), .drop_count_o(b_drop));

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic v, input logic l, input logic [31:0] d);
    a_s_tvalid = v; a_s_tlast = l; a_s_tdata = d;
  endtask

  task automatic b_beat(input logic v, input logic l, input logic [31:0] d);
    b_s_tvalid = v; b_s_tlast = l; b_s_tdata = d;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_beat(1'b1, 1'b0, 32'h1); b_beat(1'b1, 1'b0, 32'h1);
    cyc(); cyc();
    n_cmp++; if (a_gate !== 1'b0) begin n_err++; $display("FAIL reset_a_gate: got %b want 0", a_gate); end
    n_cmp++; if (a_inpkt !== 1'b0) begin n_err++; $display("FAIL reset_a_inpkt: got %b want 0", a_inpkt); end
    n_cmp++; if (a_pkt !== 4'd0) begin n_err++; $display("FAIL reset_a_pkt: got %0d want 0", a_pkt); end
    n_cmp++; if (a_s_tready !== 1'b0) begin n_err++; $display("FAIL reset_a_tready: got %b want 0", a_s_tready); end
    n_cmp++; if (a_m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_a_mvalid: got %b want 0", a_m_tvalid); end
    n_cmp++; if (b_s_tready !== 1'b0) begin n_err++; $display("FAIL reset_b_tready: got %b want 0", b_s_tready); end
    n_cmp++; if (b_drop !== 8'd0) begin n_err++; $display("FAIL reset_b_drop: got %0d want 0", b_drop); end
    a_beat(1'b0, 1'b0, 32'h0); b_beat(1'b0, 1'b0, 32'h0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_connect_forward();
    a_udt = CON; a_sv = 1'b1;
    #1;
    n_cmp++; if (a_gate !== 1'b0) begin n_err++; $display("FAIL conn_gate_before_edge: got %b want 0", a_gate); end
    cyc();
    a_sv = 1'b0;
    n_cmp++; if (a_gate !== 1'b1) begin n_err++; $display("FAIL conn_gate_after_edge: got %b want 1", a_gate); end
    for (int i = 0; i < 4; i++) begin
      a_beat(1'b1, (i == 3), 32'hA0 + i);
      #1;
      n_cmp++; if (a_m_tvalid !== 1'b1 || a_m_tdata !== 32'hA0 + i || a_s_tready !== 1'b1 || a_m_tlast !== (i == 3) || a_m_tkeep !== 4'hF)
        begin n_err++; $display("FAIL conn_beat%0d: got v=%b d=%h r=%b l=%b k=%h want v=1 d=%h r=1 l=%b k=f", i, a_m_tvalid, a_m_tdata, a_s_tready, a_m_tlast, a_m_tkeep, 32'hA0 + i, (i == 3)); end
      cyc();
    end
    a_beat(1'b0, 1'b0, 32'h0);
    n_cmp++; if (a_pkt !== 4'd1) begin n_err++; $display("FAIL conn_pkt: got %0d want 1", a_pkt); end
    n_cmp++; if (a_inpkt !== 1'b0) begin n_err++; $display("FAIL conn_inpkt: got %b want 0", a_inpkt); end
  endtask

  task automatic test_close_drain();
    for (int i = 0; i < 5; i++) begin
      a_beat(1'b1, (i == 4), 32'hB0 + i);
      if (i == 1) begin a_udt = CLS; a_sv = 1'b1; end
      #1;
      if (i >= 2) begin
        n_cmp++; if (a_m_tvalid !== 1'b1 || a_m_tdata !== 32'hB0 + i) begin n_err++; $display("FAIL drain_beat%0d: got v=%b d=%h want v=1 d=%h", i, a_m_tvalid, a_m_tdata, 32'hB0 + i); end
      end
      cyc();
      a_sv = 1'b0;
      if (i == 1) begin
        n_cmp++; if (a_gate !== 1'b1 || a_inpkt !== 1'b1) begin n_err++; $display("FAIL drain_entered: got gate=%b inpkt=%b want 1 1", a_gate, a_inpkt); end
      end
    end
    n_cmp++; if (a_gate !== 1'b0) begin n_err++; $display("FAIL drain_closed: got %b want 0", a_gate); end
    n_cmp++; if (a_pkt !== 4'd2) begin n_err++; $display("FAIL drain_pkt: got %0d want 2", a_pkt); end
    a_beat(1'b1, 1'b0, 32'hC0);
    #1;
    n_cmp++; if (a_s_tready !== 1'b0 || a_m_tvalid !== 1'b0) begin n_err++; $display("FAIL closed_stall: got r=%b v=%b want 0 0", a_s_tready, a_m_tvalid); end
    cyc();
    n_cmp++; if (a_inpkt !== 1'b0 || a_pkt !== 4'd2) begin n_err++; $display("FAIL closed_hold: got inpkt=%b pkt=%0d want 0 2", a_inpkt, a_pkt); end
    a_beat(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_drain_connect();
    a_udt = CON; a_sv = 1'b1; cyc(); a_sv = 1'b0;
    a_m_tready = 1'b0; a_beat(1'b1, 1'b0, 32'hD0);
    #1;
    n_cmp++; if (a_s_tready !== 1'b0 || a_m_tvalid !== 1'b1) begin n_err++; $display("FAIL open_backpressure: got r=%b v=%b want 0 1", a_s_tready, a_m_tvalid); end
    a_m_tready = 1'b1;
    a_udt = CLS; a_sv = 1'b1; cyc(); a_sv = 1'b0;
    n_cmp++; if (a_gate !== 1'b1 || a_inpkt !== 1'b1) begin n_err++; $display("FAIL dc_drain: got gate=%b inpkt=%b want 1 1", a_gate, a_inpkt); end
    a_beat(1'b1, 1'b1, 32'hD1); a_udt = CON; a_sv = 1'b1; cyc(); a_sv = 1'b0;
    a_beat(1'b0, 1'b0, 32'h0);
    n_cmp++; if (a_gate !== 1'b1 || a_pkt !== 4'd3 || a_inpkt !== 1'b0) begin n_err++; $display("FAIL dc_reopen: got gate=%b pkt=%0d inpkt=%b want 1 3 0", a_gate, a_pkt, a_inpkt); end
    a_udt = CLS; a_sv = 1'b1; cyc(); a_sv = 1'b0;
    n_cmp++; if (a_gate !== 1'b0) begin n_err++; $display("FAIL dc_was_open: got %b want 0", a_gate); end
  endtask

  task automatic test_ignore_code();
    a_udt = CON; a_sv = 1'b1; cyc();
    a_udt = 32'h0000_0005; cyc();
    n_cmp++; if (a_gate !== 1'b1) begin n_err++; $display("FAIL ignore_code5: got %b want 1", a_gate); end
    a_udt = CLS; a_sv = 1'b0; cyc();
    n_cmp++; if (a_gate !== 1'b1) begin n_err++; $display("FAIL ignore_novalid: got %b want 1", a_gate); end
  endtask

  task automatic test_saturation();
    a_beat(1'b1, 1'b1, 32'hE0);
    for (int i = 0; i < 11; i++) cyc();
    n_cmp++; if (a_pkt !== 4'd14) begin n_err++; $display("FAIL sat_mid: got %0d want 14", a_pkt); end
    for (int i = 0; i < 6; i++) cyc();
    n_cmp++; if (a_pkt !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d want 15", a_pkt); end
    a_beat(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_midpacket();
    a_beat(1'b1, 1'b0, 32'hF0); cyc();
    n_cmp++; if (a_inpkt !== 1'b1) begin n_err++; $display("FAIL mid_inpkt: got %b want 1", a_inpkt); end
    a_rst_n = 1'b0;
    #1;
    n_cmp++; if (a_gate !== 1'b0 || a_inpkt !== 1'b0 || a_pkt !== 4'd0 || a_s_tready !== 1'b0 || a_m_tvalid !== 1'b0)
      begin n_err++; $display("FAIL mid_reset: got gate=%b inpkt=%b pkt=%0d r=%b v=%b want 0 0 0 0 0", a_gate, a_inpkt, a_pkt, a_s_tready, a_m_tvalid); end
    cyc();
    a_beat(1'b0, 1'b0, 32'h0); a_rst_n = 1'b1; cyc();
    a_udt = CON; a_sv = 1'b1; cyc(); a_sv = 1'b0;
    a_beat(1'b1, 1'b1, 32'hF1); cyc(); a_beat(1'b0, 1'b0, 32'h0);
    n_cmp++; if (a_pkt !== 4'd1 || a_inpkt !== 1'b0) begin n_err++; $display("FAIL post_reset_pkt: got pkt=%0d inpkt=%b want 1 0", a_pkt, a_inpkt); end
  endtask

  task automatic test_drop_sync();
    b_beat(1'b1, 1'b0, 32'h10);
    #1;
    n_cmp++; if (b_s_tready !== 1'b1 || b_m_tvalid !== 1'b0) begin n_err++; $display("FAIL drop_accept: got r=%b v=%b want 1 0", b_s_tready, b_m_tvalid); end
    cyc();
    n_cmp++; if (b_inpkt !== 1'b1) begin n_err++; $display("FAIL drop_inpkt: got %b want 1", b_inpkt); end
    b_beat(1'b1, 1'b0, 32'h11); b_udt = CON; b_sv = 1'b1; cyc(); b_sv = 1'b0;
    n_cmp++; if (b_gate !== 1'b0) begin n_err++; $display("FAIL sync_gate: got %b want 0", b_gate); end
    b_beat(1'b1, 1'b1, 32'h12);
    #1;
    n_cmp++; if (b_m_tvalid !== 1'b0) begin n_err++; $display("FAIL sync_discard: got %b want 0", b_m_tvalid); end
    cyc();
    n_cmp++; if (b_gate !== 1'b1 || b_drop !== 8'd1 || b_pkt !== 8'd0) begin n_err++; $display("FAIL sync_open: got gate=%b drop=%0d pkt=%0d want 1 1 0", b_gate, b_drop, b_pkt); end
    for (int i = 0; i < 2; i++) begin
      b_beat(1'b1, (i == 1), 32'h20 + i);
      #1;
      n_cmp++; if (b_m_tvalid !== 1'b1 || b_m_tdata !== 32'h20 + i) begin n_err++; $display("FAIL sync_fwd%0d: got v=%b d=%h want 1 %h", i, b_m_tvalid, b_m_tdata, 32'h20 + i); end
      cyc();
    end
    b_beat(1'b0, 1'b0, 32'h0);
    n_cmp++; if (b_pkt !== 8'd1) begin n_err++; $display("FAIL sync_pkt: got %0d want 1", b_pkt); end
  endtask

  task automatic test_sync_close();
    b_udt = CLS; b_sv = 1'b1; cyc(); b_sv = 1'b0;
    n_cmp++; if (b_gate !== 1'b0) begin n_err++; $display("FAIL sc_closed: got %b want 0", b_gate); end
    b_beat(1'b1, 1'b0, 32'h30); cyc(); b_beat(1'b0, 1'b0, 32'h0);
    b_udt = CON; b_sv = 1'b1; cyc(); b_sv = 1'b0;
    n_cmp++; if (b_gate !== 1'b0 || b_inpkt !== 1'b1) begin n_err++; $display("FAIL sc_sync: got gate=%b inpkt=%b want 0 1", b_gate, b_inpkt); end
    b_beat(1'b1, 1'b1, 32'h31); b_udt = CLS; b_sv = 1'b1; cyc(); b_sv = 1'b0;
    b_beat(1'b0, 1'b0, 32'h0);
    n_cmp++; if (b_gate !== 1'b0 || b_drop !== 8'd2) begin n_err++; $display("FAIL sc_close_wins: got gate=%b drop=%0d want 0 2", b_gate, b_drop); end
    b_udt = CON; b_sv = 1'b1; cyc(); b_sv = 1'b0;
    n_cmp++; if (b_gate !== 1'b1) begin n_err++; $display("FAIL sc_was_closed: got %b want 1", b_gate); end
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_s_tdata = '0; a_s_tkeep = 4'hF; a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_m_tready = 1'b1;
    a_udt = '0; a_sv = 1'b0;
    b_s_tdata = '0; b_s_tkeep = 4'hF; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b1;
    b_udt = '0; b_sv = 1'b0;
    test_reset();
    test_connect_forward();
    test_close_drain();
    test_drain_connect();
    test_ignore_code();
    test_saturation();
    test_reset_midpacket();
    test_drop_sync();
    test_sync_close();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
